// File: rtl/psg_bus_pkg.sv
// Shared types for the PSG bus scheduler: FSM states, requester ids and
// the width of the phase cycle counter.
package psg_bus_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    READ,
    RECOV
  } state_t;

  typedef enum logic {
    P0,
    P1
  } grant_t;

endpackage

// File: rtl/psg_wr_fifo.sv
// Sequencer write FIFO: entries are {addr[3:0], data[7:0]}. The head is
// presented combinationally, so a pop consumes the entry visible in the same
// cycle. DEPTH must be a power of two so the pointers wrap naturally.
module psg_wr_fifo #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic        pop,
  input  logic [11:0] din,
  output logic [11:0] head,
  output logic [4:0]  level,
  output logic        full,
  output logic        empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [11:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Storage array: written on push, holds no control state so needs no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // Pointers and occupancy; a simultaneous push and pop leaves level unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level <= level + 5'd1;
        2'b01:   level <= level - 5'd1;
        default: level <= level;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (level == 5'(DEPTH));
  assign empty = (level == 5'd0);

endmodule

// File: rtl/psg_bus_sched.sv
// Arbitrates host (port 0) and sequencer FIFO (port 1) accesses onto the PSG
// register bus. Each access runs SETUP -> STROBE/READ -> RECOV so every write
// gets its own falling and rising edge of psg_wr_n.
module psg_bus_sched
  import psg_bus_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int WR_CYC     = 2,
  parameter int RD_CYC     = 2,
  parameter int GAP_CYC    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       p0_valid,
  output logic       p0_ready,
  input  logic       p0_we,
  input  logic [3:0] p0_addr,
  input  logic [7:0] p0_wdata,
  output logic [7:0] p0_rdata,
  output logic       p0_rvalid,
  input  logic       p1_valid,
  output logic       p1_ready,
  input  logic [3:0] p1_addr,
  input  logic [7:0] p1_wdata,
  output logic [3:0] psg_addr,
  output logic [7:0] psg_din,
  output logic       psg_cs_n,
  output logic       psg_wr_n,
  input  logic [7:0] psg_dout,
  output logic       busy,
  output logic [4:0] fifo_level
);

  localparam logic [CNT_W-1:0] WR_LAST  = CNT_W'(WR_CYC - 1);
  localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(RD_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC - 1);

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nx;
  grant_t           last_grant;
  grant_t           grant_sel;
  logic             grant_vld;
  logic             cur_we;
  logic             cs_n_nx;
  logic             wr_n_nx;
  logic             rd_last;

  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [11:0]      fifo_head;

  psg_wr_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   ({p1_addr, p1_wdata}),
    .head  (fifo_head),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Full blocks pushes even if a pop happens this cycle: no bypass path.
  assign p1_ready  = !fifo_full;
  assign fifo_push = p1_valid && !fifo_full;
  assign fifo_pop  = grant_vld && (grant_sel == P1);

  // Host is only offered a slot when it would actually win arbitration.
  assign p0_ready = (state == IDLE) && (fifo_empty || (last_grant == P1));
  assign busy     = (state != IDLE) || !fifo_empty;
  assign rd_last  = (state == READ) && (cnt == '0);

  // Round-robin on contention, otherwise serve whichever side is pending.
  always_comb begin
    grant_vld = 1'b0;
    grant_sel = P0;
    if (state == IDLE) begin
      if (p0_valid && !fifo_empty) begin
        grant_vld = 1'b1;
        grant_sel = (last_grant == P1) ? P0 : P1;
      end else if (p0_valid) begin
        grant_vld = 1'b1;
        grant_sel = P0;
      end else if (!fifo_empty) begin
        grant_vld = 1'b1;
        grant_sel = P1;
      end
    end
  end

  // Next-state and phase counter: counter holds remaining cycles minus one.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      IDLE: begin
        if (grant_vld) begin
          state_nx = SETUP;
          cnt_nx   = '0;
        end
      end
      SETUP: begin
        state_nx = cur_we ? STROBE : READ;
        cnt_nx   = cur_we ? WR_LAST : RD_LAST;
      end
      STROBE, READ: begin
        if (cnt == '0) begin
          state_nx = RECOV;
          cnt_nx   = GAP_LAST;
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      RECOV: begin
        if (cnt == '0) state_nx = IDLE;
        else           cnt_nx   = cnt - CNT_W'(1);
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // Bus strobes derived from the upcoming state so they can be registered.
  always_comb begin
    cs_n_nx = !((state_nx == SETUP) || (state_nx == STROBE) || (state_nx == READ));
    wr_n_nx = (state_nx != STROBE);
  end

  // Control state and registered strobes; reset returns the bus to idle at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      last_grant <= P1;
      psg_cs_n   <= 1'b1;
      psg_wr_n   <= 1'b1;
      p0_rvalid  <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      psg_cs_n  <= cs_n_nx;
      psg_wr_n  <= wr_n_nx;
      p0_rvalid <= rd_last;
      if (grant_vld) last_grant <= grant_sel;
    end
  end

  // Access descriptor captured on grant and held until the next grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psg_addr <= '0;
      psg_din  <= '0;
      cur_we   <= 1'b0;
      p0_rdata <= '0;
    end else begin
      if (grant_vld) begin
        if (grant_sel == P0) begin
          psg_addr <= p0_addr;
          psg_din  <= p0_wdata;
          cur_we   <= p0_we;
        end else begin
          psg_addr <= fifo_head[11:8];
          psg_din  <= fifo_head[7:0];
          cur_we   <= 1'b1;
        end
      end
      if (rd_last) p0_rdata <= psg_dout;
    end
  end

endmodule

// File: tb/tb_psg_bus_sched.sv
// Bench for psg_bus_sched: directed scenarios plus random traffic, checked
// cycle by cycle against a transaction-level model of the scheduler.
module tb_psg_bus_sched;

  localparam int FIFO_DEPTH = 4;
  localparam int WR_CYC     = 2;
  localparam int RD_CYC     = 2;
  localparam int GAP_CYC    = 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       p0_valid, p0_ready, p0_we, p0_rvalid;
  logic [3:0] p0_addr;
  logic [7:0] p0_wdata, p0_rdata;
  logic       p1_valid, p1_ready;
  logic [3:0] p1_addr;
  logic [7:0] p1_wdata;
  logic [3:0] psg_addr;
  logic [7:0] psg_din;
  logic       psg_cs_n, psg_wr_n;
  logic [7:0] psg_dout = 8'h00;
  logic       busy;
  logic [4:0] fifo_level;

  always #5 clk = ~clk;

  psg_bus_sched #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .WR_CYC     (WR_CYC),
    .RD_CYC     (RD_CYC),
    .GAP_CYC    (GAP_CYC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .p0_valid   (p0_valid),
    .p0_ready   (p0_ready),
    .p0_we      (p0_we),
    .p0_addr    (p0_addr),
    .p0_wdata   (p0_wdata),
    .p0_rdata   (p0_rdata),
    .p0_rvalid  (p0_rvalid),
    .p1_valid   (p1_valid),
    .p1_ready   (p1_ready),
    .p1_addr    (p1_addr),
    .p1_wdata   (p1_wdata),
    .psg_addr   (psg_addr),
    .psg_din    (psg_din),
    .psg_cs_n   (psg_cs_n),
    .psg_wr_n   (psg_wr_n),
    .psg_dout   (psg_dout),
    .busy       (busy),
    .fifo_level (fifo_level)
  );

  // PSG register read port: registered, one cycle from address to data.
  function automatic logic [7:0] rom_val(input logic [3:0] a);
    return (a == 4'd7) ? 8'h3F : {a, ~a};
  endfunction

  always @(posedge clk) psg_dout <= rom_val(psg_addr);

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Transaction-level model: one access in flight described by its grant
  // cycle and kind; the FIFO is a plain queue.
  int          cyc, t_free, g_cyc;
  bit          m_we, last_p1;
  logic [3:0]  m_addr;
  logic [7:0]  m_din, m_rdata;
  logic [11:0] q[$];
  logic [11:0] obs[$];
  logic        prev_wr_n;
  int          n_rise, n_fall, n_rv, peak, last_rise, min_gap;

  task automatic model_reset();
    cyc = 0; t_free = 0; g_cyc = -1000;
    m_we = 1'b1; last_p1 = 1'b1;
    m_addr = '0; m_din = '0; m_rdata = '0;
    q.delete(); obs.delete();
    prev_wr_n = 1'b1;
    n_rise = 0; n_fall = 0; n_rv = 0; peak = 0; last_rise = -1; min_gap = 1000;
  endtask

  function automatic logic [11:0] obs_at(input int i);
    return (i < obs.size()) ? obs[i] : 12'hxxx;
  endfunction

  // One clock cycle: drive inputs, compare all outputs at the falling edge,
  // then advance the model to what the next rising edge should produce.
  task automatic step(input bit v0, input bit we0, input logic [3:0] a0, input logic [7:0] d0,
                      input bit v1, input logic [3:0] a1, input logic [7:0] d1);
    bit idle, gnt, gp1, push;
    int acc_len;
    p0_valid = v0; p0_we = we0; p0_addr = a0; p0_wdata = d0;
    p1_valid = v1; p1_addr = a1; p1_wdata = d1;
    @(negedge clk);
    idle    = (cyc >= t_free);
    acc_len = m_we ? WR_CYC : RD_CYC;
    if (!m_we && cyc == g_cyc + 2 + RD_CYC) m_rdata = rom_val(m_addr);
    chk("p0_ready",   32'(p0_ready),   32'(idle && (q.size() == 0 || last_p1)));
    chk("p1_ready",   32'(p1_ready),   32'(q.size() < FIFO_DEPTH));
    chk("fifo_level", 32'(fifo_level), 32'(q.size()));
    chk("busy",       32'(busy),       32'(!idle || q.size() != 0));
    chk("psg_cs_n",   32'(psg_cs_n),   32'(!(cyc >= g_cyc + 1 && cyc < g_cyc + 2 + acc_len)));
    chk("psg_wr_n",   32'(psg_wr_n),   32'(!(m_we && cyc >= g_cyc + 2 && cyc < g_cyc + 2 + WR_CYC)));
    chk("psg_addr",   32'(psg_addr),   32'(m_addr));
    chk("psg_din",    32'(psg_din),    32'(m_din));
    chk("p0_rvalid",  32'(p0_rvalid),  32'(!m_we && cyc == g_cyc + 2 + RD_CYC));
    chk("p0_rdata",   32'(p0_rdata),   32'(m_rdata));
    if (p0_rvalid) n_rv++;
    if (fifo_level > peak) peak = fifo_level;
    if (prev_wr_n === 1'b0 && psg_wr_n === 1'b1) begin
      obs.push_back({psg_addr, psg_din});
      n_rise++;
      last_rise = cyc;
    end
    if (prev_wr_n === 1'b1 && psg_wr_n === 1'b0) begin
      n_fall++;
      if (last_rise >= 0 && cyc - last_rise < min_gap) min_gap = cyc - last_rise;
    end
    prev_wr_n = psg_wr_n;

    push = v1 && (q.size() < FIFO_DEPTH);
    if (idle) begin
      gnt = 1'b0; gp1 = 1'b0;
      if (v0 && q.size() != 0) begin gnt = 1'b1; gp1 = !last_p1; end
      else if (v0)             begin gnt = 1'b1; gp1 = 1'b0; end
      else if (q.size() != 0)  begin gnt = 1'b1; gp1 = 1'b1; end
      if (gnt) begin
        g_cyc   = cyc;
        last_p1 = gp1;
        if (gp1) begin
          {m_addr, m_din} = q.pop_front();
          m_we = 1'b1;
        end else begin
          m_addr = a0; m_din = d0; m_we = we0;
        end
        t_free = cyc + 2 + (m_we ? WR_CYC : RD_CYC) + GAP_CYC;
      end
    end
    if (push) q.push_back({a1, d1});
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 4'd0, 8'd0);
  endtask

  initial begin
    bit found;
    int rv0;
    p0_valid = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0;
    p1_valid = 0; p1_addr = '0; p1_wdata = '0;
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cs_n",  32'(psg_cs_n),   32'd1);
    chk("rst_wr_n",  32'(psg_wr_n),   32'd1);
    chk("rst_addr",  32'(psg_addr),   32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_rdata", 32'(p0_rdata),   32'd0);
    rst_n = 1'b1;

    // Reset asserted while the strobe is low, with a sequencer entry queued.
    step(1'b1, 1'b1, 4'd8, 8'h0F, 1'b1, 4'd3, 8'h77);
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      if (psg_wr_n === 1'b0) found = 1'b1;
      else idle_steps(1);
    end
    chk("rst_mid_found", 32'(found), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_wr_n",  32'(psg_wr_n),   32'd1);
    chk("rst_mid_cs_n",  32'(psg_cs_n),   32'd1);
    chk("rst_mid_level", 32'(fifo_level), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    idle_steps(2);

    // Single host write.
    obs.delete();
    step(1'b1, 1'b1, 4'd8, 8'h0F, 1'b0, 4'd0, 8'd0);
    idle_steps(6);
    chk("hw_count", 32'(obs.size()), 32'd1);
    chk("hw_entry", 32'(obs_at(0)),  32'h80F);

    // Host read of register 7.
    rv0 = n_rv;
    step(1'b1, 1'b0, 4'd7, 8'h00, 1'b0, 4'd0, 8'd0);
    idle_steps(6);
    chk("rd_pulses", 32'(n_rv - rv0), 32'd1);
    chk("rd_data",   32'(p0_rdata),   32'h3F);

    // Sequencer burst of five writes.
    obs.delete(); peak = 0;
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 4'd0, 8'd0, 1'b1, 4'(i), 8'hA0 + 8'(i));
    idle_steps(30);
    chk("burst_count", 32'(obs.size()), 32'd5);
    for (int i = 0; i < 5; i++) chk("burst_order", 32'(obs_at(i)), 32'({4'(i), 8'hA0 + 8'(i)}));
    chk("burst_peak", 32'(peak), 32'd4);

    // Both ports continuously pending: grants must alternate.
    obs.delete(); n_rise = 0; n_fall = 0;
    repeat (20) step(1'b1, 1'b1, 4'd13, 8'h0E, 1'b1, 4'd1, 8'h55);
    idle_steps(30);
    chk("alt_0", 32'(obs_at(0)), 32'hD0E);
    chk("alt_1", 32'(obs_at(1)), 32'h155);
    chk("alt_2", 32'(obs_at(2)), 32'hD0E);
    chk("alt_3", 32'(obs_at(3)), 32'h155);
    chk("alt_edges", 32'(n_fall), 32'(n_rise));

    // Back-to-back sequencer writes to the envelope shape register.
    obs.delete(); last_rise = -1; min_gap = 1000;
    step(1'b0, 1'b0, 4'd0, 8'd0, 1'b1, 4'd13, 8'h0E);
    step(1'b0, 1'b0, 4'd0, 8'd0, 1'b1, 4'd13, 8'h0F);
    idle_steps(15);
    chk("env_count", 32'(obs.size()), 32'd2);
    chk("env_gap_ok", 32'(min_gap >= GAP_CYC), 32'd1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
           8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
           8'($urandom_range(0, 255)));
    end
    idle_steps(30);
    chk("final_idle", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
